// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// Carries operands and op select in, busy/done/result and an FSM state view out.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is a request that is taken on any rising edge where the
    // unit is not busy and flush is low. There is no ready signal; the master
    // reads busy. done pulses for one cycle when result is valid, and result
    // holds until the next accepted start.
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [1:0]       state_dbg;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, result, state_dbg
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, result, state_dbg
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit
// per cycle, with divide-by-zero and signed overflow resolved in one cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] res_q;

    logic             busy;
    logic             done;

    // Operand decode at the accepting edge
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             sgn_ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic             accept;

    // One restoring step
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fin_res;

    always_comb begin
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        // MIN_NEG negates to itself, which is also its correct unsigned magnitude.
        a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
        div_zero  = (bus.b == '0);
        sgn_ovf   = in_signed & (bus.a == MIN_NEG) & (bus.b == '1);
        special   = div_zero | sgn_ovf;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else begin
            special_res = bus.op[1] ? '0 : MIN_NEG;
        end
        accept = bus.start & ~bus.flush & (state_q != S_CALC);
    end

    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        qbit      = ~trial[WIDTH];
        rem_next  = qbit ? trial : rem_shift;
        quo_next  = {quo_q[WIDTH-2:0], qbit};
        last      = (cnt_q == LAST);
        quo_fix   = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix   = neg_rem_q ? (~rem_next[WIDTH-1:0] + 1'b1) : rem_next[WIDTH-1:0];
        fin_res   = is_rem_q ? rem_fix : quo_fix;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = special ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d = S_IDLE;
        end
    end

    // FSM: outputs decoded from state only
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    // Datapath; result only moves on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            is_rem_q  <= bus.op[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (special) begin
                res_q <= special_res;
            end
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + CW'(1);
            quo_q <= quo_next;
            rem_q <= rem_next;
            if (last) begin
                res_q <= fin_res;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = res_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases from the operation rules plus randomized
// operations checked against a plain-arithmetic reference.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
  localparam logic [W-1:0] ALL1    = 32'hFFFF_FFFF;
  localparam int LAT = 32;

  logic clk;
  logic rst;
  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: RISC-V M semantics straight from integer arithmetic
  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return op[1] ? a : ALL1;
    if (op[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = $signed(a);
      sb = $signed(b);
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == MIN_NEG && b == ALL1);
  endfunction

  // driver tasks
  task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Wait for done, counting busy cycles; leaves the caller in the DONE cycle.
  task automatic collect(input int exp_busy, output int waited);
    int nb;
    int t;
    nb = 0;
    t  = 0;
    while (!bus.done && t < 200) begin
      if (bus.busy) nb++;
      @(negedge clk);
      t++;
    end
    waited = t;
    check("done_seen", 32'(bus.done), 32'd1);
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    check("busy_in_done", 32'(bus.busy), 32'd0);
    if (exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      check("result", bus.result, last_res);
    end else begin
      check("exp_q_empty", 32'd0, 32'd1);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int t;
    exp_q.push_back(exp);
    @(negedge clk);
    drive_start(op, a, b);
    collect(is_special(op, a, b) ? 0 : LAT, t);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("result_hold", bus.result, last_res);
  endtask

  initial begin
    int t;
    int nd;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    n_vec = 0;
    n_err = 0;
    last_res = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);

    // normal unsigned and signed cases
    run_op(2'b01, 32'd100, 32'd7, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 32'd2);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

    // single-cycle special cases
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd5, 32'd0, 32'd5);
    run_op(2'b00, MIN_NEG, ALL1, MIN_NEG);
    run_op(2'b10, MIN_NEG, ALL1, 32'd0);
    run_op(2'b01, MIN_NEG, ALL1, 32'd0);

    // flush mid-calculation, coinciding with a competing start
    @(negedge clk);
    drive_start(2'b01, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.a = 32'd50;
    bus.b = 32'd5;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result", bus.result, last_res);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    check("flush_quiet", 32'(nd), 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 32'd3);

    // reset mid-calculation
    @(negedge clk);
    drive_start(2'b01, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);

    // start while busy is ignored
    exp_q.push_back(32'd100);
    @(negedge clk);
    drive_start(2'b01, 32'd1000, 32'd10);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.a = 32'd77;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    collect(LAT - 6, t);
    @(negedge clk);

    // back-to-back: second start in the DONE cycle
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd100);
    @(negedge clk);
    drive_start(2'b01, 32'd100, 32'd7);
    collect(LAT, t);
    drive_start(2'b01, 32'd1000, 32'd10);
    collect(LAT, t);
    check("b2b_gap", 32'(t + 1), 32'(LAT + 1));
    @(negedge clk);
    check("b2b_pulse", 32'(bus.done), 32'd0);

    // randomized operations against the reference
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = MIN_NEG; rb = ALL1; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = ALL1;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(rop, ra, rb, ref_model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
